// File: rtl/mdu_unit.sv
// mdu_unit: multiply/divide unit owning the HI/LO registers of the pipelined core.
// A start pulse launches mult/div (fixed-latency busy window) or an mthi/mtlo write.
module mdu_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  md_op,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic [31:0]        pend_hi_q, pend_hi_d;
    logic [31:0]        pend_lo_q, pend_lo_d;
    logic               pend_wr_q, pend_wr_d;

    logic [63:0]        prod_s;
    logic [63:0]        prod_u;
    logic [31:0]        a_mag;
    logic [31:0]        b_mag;
    logic [31:0]        div_u_den;
    logic [31:0]        div_s_den;
    logic [31:0]        quot_u;
    logic [31:0]        rem_u;
    logic [31:0]        quot_mag;
    logic [31:0]        rem_mag;
    logic [31:0]        quot_s;
    logic [31:0]        rem_s;

    // Result datapath; signed divide works on magnitudes so MIN/-1 wraps cleanly.
    always_comb begin
        prod_s    = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
        prod_u    = {32'd0, rs_val} * {32'd0, rt_val};
        a_mag     = rs_val[31] ? (~rs_val + 32'd1) : rs_val;
        b_mag     = rt_val[31] ? (~rt_val + 32'd1) : rt_val;
        div_u_den = (rt_val == 32'd0) ? 32'd1 : rt_val;
        div_s_den = (b_mag == 32'd0) ? 32'd1 : b_mag;
        quot_u    = rs_val / div_u_den;
        rem_u     = rs_val % div_u_den;
        quot_mag  = a_mag / div_s_den;
        rem_mag   = a_mag % div_s_den;
        quot_s    = (rs_val[31] ^ rt_val[31]) ? (~quot_mag + 32'd1) : quot_mag;
        rem_s     = rs_val[31] ? (~rem_mag + 32'd1) : rem_mag;
    end

    // Next-state: launch from idle, count down while busy, commit on the last edge.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (md_op)
                        OP_MULT: begin
                            pend_hi_d = prod_s[63:32];
                            pend_lo_d = prod_s[31:0];
                            pend_wr_d = 1'b1;
                            cnt_d     = CNT_W'(MULT_CYCLES);
                            state_d   = S_BUSY;
                        end
                        OP_MULTU: begin
                            pend_hi_d = prod_u[63:32];
                            pend_lo_d = prod_u[31:0];
                            pend_wr_d = 1'b1;
                            cnt_d     = CNT_W'(MULT_CYCLES);
                            state_d   = S_BUSY;
                        end
                        OP_DIV: begin
                            pend_hi_d = rem_s;
                            pend_lo_d = quot_s;
                            pend_wr_d = (rt_val != 32'd0);
                            cnt_d     = CNT_W'(DIV_CYCLES);
                            state_d   = S_BUSY;
                        end
                        OP_DIVU: begin
                            pend_hi_d = rem_u;
                            pend_lo_d = quot_u;
                            pend_wr_d = (rt_val != 32'd0);
                            cnt_d     = CNT_W'(DIV_CYCLES);
                            state_d   = S_BUSY;
                        end
                        OP_MTHI: hi_d = rs_val;
                        OP_MTLO: lo_d = rs_val;
                        default: ;
                    endcase
                end
            end
            S_BUSY: begin
                if (cnt_q == CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d == S_BUSY);
    end

    // State and architectural registers; reset discards any in-flight result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    assign busy = busy_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: directed vectors with a scoreboard queue checked on each busy window close.
module tb_mdu_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .md_op  (md_op),
        .rs_val (rs_val),
        .rt_val (rt_val),
        .busy   (busy),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] old_hi;
        logic [31:0] old_lo;
        int          len;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, req);
    endtask

    task automatic expect_op(input logic [31:0] h, input logic [31:0] l,
                             input logic [31:0] oh, input logic [31:0] ol, input int n);
        exp_t e;
        e.hi = h; e.lo = l; e.old_hi = oh; e.old_lo = ol; e.len = n;
        exp_q.push_back(e);
    endtask

    // One-cycle start pulse; returns at the negedge right after the start edge.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; md_op = op; rs_val = a; rt_val = b;
        @(negedge clk);
        start = 1'b0; md_op = 3'd0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy === 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (busy !== 1'b0) chk("wait_idle_timeout", 32'(busy), 32'd0);
    endtask

    // Monitor: measures each busy window and checks HI/LO hold and final result.
    logic in_flight = 1'b0;
    int   win_len   = 0;
    logic hold_ok   = 1'b1;
    always @(negedge clk) begin
        if (busy === 1'b1) begin
            if (!in_flight) begin
                in_flight = 1'b1;
                win_len   = 0;
                hold_ok   = 1'b1;
            end
            win_len++;
            if (exp_q.size() > 0 && (hi !== exp_q[0].old_hi || lo !== exp_q[0].old_lo))
                hold_ok = 1'b0;
        end else if (in_flight) begin
            in_flight = 1'b0;
            if (exp_q.size() == 0) begin
                chk("unexpected_op", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("busy_len", 32'(win_len), 32'(e.len));
                chk("hold_during_busy", 32'(hold_ok), 32'd1);
                chk("hi_result", hi, e.hi);
                chk("lo_result", lo, e.lo);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; start = 1'b0; md_op = 3'd0; rs_val = '0; rt_val = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_hi", hi, 32'd0);
        chk("reset_lo", lo, 32'd0);
        reset = 1'b0;

        // mult -2 * 3
        expect_op(32'hFFFFFFFF, 32'hFFFFFFFA, 32'd0, 32'd0, 5);
        issue(3'd1, 32'hFFFFFFFE, 32'h00000003);
        wait_idle();

        // multu max * max
        expect_op(32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFF, 32'hFFFFFFFA, 5);
        issue(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_idle();

        // div -7 / 2
        expect_op(32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'h00000001, 10);
        issue(3'd3, 32'hFFFFFFF9, 32'd2);
        wait_idle();

        // divu 7 / 2
        expect_op(32'd1, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFD, 10);
        issue(3'd4, 32'd7, 32'd2);
        wait_idle();

        // div 7 / -2
        expect_op(32'd1, 32'hFFFFFFFD, 32'd1, 32'd3, 10);
        issue(3'd3, 32'd7, 32'hFFFFFFFE);
        wait_idle();

        // div overflow MIN / -1
        expect_op(32'd0, 32'h80000000, 32'd1, 32'hFFFFFFFD, 10);
        issue(3'd3, 32'h80000000, 32'hFFFFFFFF);
        wait_idle();

        // back-to-back mthi / mtlo
        @(negedge clk);
        start = 1'b1; md_op = 3'd5; rs_val = 32'h12345678;
        @(negedge clk);
        chk("mthi_hi", hi, 32'h12345678);
        chk("mthi_lo_kept", lo, 32'h80000000);
        chk("mthi_busy", 32'(busy), 32'd0);
        md_op = 3'd6; rs_val = 32'h9ABCDEF0;
        @(negedge clk);
        start = 1'b0; md_op = 3'd0;
        chk("mtlo_lo", lo, 32'h9ABCDEF0);
        chk("mtlo_hi_kept", hi, 32'h12345678);
        chk("mtlo_busy", 32'(busy), 32'd0);

        // div by zero leaves HI/LO untouched
        expect_op(32'h12345678, 32'h9ABCDEF0, 32'h12345678, 32'h9ABCDEF0, 10);
        issue(3'd3, 32'd55, 32'd0);
        wait_idle();

        // mult 3*4 with starts and operand changes during busy
        expect_op(32'd0, 32'd12, 32'h12345678, 32'h9ABCDEF0, 5);
        issue(3'd1, 32'd3, 32'd4);
        start = 1'b1; md_op = 3'd5; rs_val = 32'h0000DEAD;
        @(negedge clk);
        md_op = 3'd3; rs_val = 32'd100; rt_val = 32'd1;
        @(negedge clk);
        start = 1'b0; md_op = 3'd0;
        wait_idle();

        // div 100/7 aborted by reset after four busy cycles
        expect_op(32'd0, 32'd0, 32'd0, 32'd12, 4);
        issue(3'd3, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        repeat (12) @(negedge clk);
        chk("no_late_hi", hi, 32'd0);
        chk("no_late_lo", lo, 32'd0);

        // mult 2*3, with an mtlo arriving on the edge busy falls
        expect_op(32'd0, 32'd6, 32'd0, 32'd0, 5);
        issue(3'd1, 32'd2, 32'd3);
        repeat (4) @(negedge clk);
        start = 1'b1; md_op = 3'd6; rs_val = 32'h0000BEEF;
        @(negedge clk);
        start = 1'b0; md_op = 3'd0;
        chk("falling_edge_busy", 32'(busy), 32'd0);
        chk("falling_edge_mtlo_ignored", lo, 32'd6);

        // mtlo accepted once idle
        issue(3'd6, 32'h0000BEEF, 32'd0);
        chk("idle_mtlo", lo, 32'h0000BEEF);
        chk("idle_mtlo_busy", 32'(busy), 32'd0);

        // reserved and none opcodes do nothing
        issue(3'd7, 32'h11111111, 32'd1);
        issue(3'd0, 32'h22222222, 32'd1);
        chk("nop_busy", 32'(busy), 32'd0);
        chk("nop_hi", hi, 32'd0);
        chk("nop_lo", lo, 32'h0000BEEF);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multiply/divide unit for the P6 pipelined mips core; sits beside the EX-stage ALU and owns the HI/LO registers.
- The pipeline initiates an operation with a one-cycle start pulse. The unit responds with a registered busy flag for a fixed latency, then commits HI/LO.
- The pipeline stalls on (start || busy) for later mult/div/mfhi/mflo/mthi/mtlo instructions. The unit itself never queues work.

Parameters:
- MULT_CYCLES, 5, busy cycles for mult/multu (must be >=1)
- DIV_CYCLES, 10, busy cycles for div/divu (must be >=1)

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state
- start  input  1  one-cycle request from EX stage, qualifies md_op
- md_op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved
- rs_val  input  32  operand A (dividend / multiplicand / mthi-mtlo source)
- rt_val  input  32  operand B (divisor / multiplier)
- busy  output  1  registered; high while a mult/div is in flight
- hi  output  32  current HI register (direct register output, no bypass)
- lo  output  32  current LO register

Behaviour:
- Clock and reset: one clock domain (clk); reset is synchronous and active-high.
- Reset: at any edge with reset=1, busy=0, counter=0, hi=0, lo=0, and any pending result is discarded. Reset takes priority over everything, including mid-operation.
- Idle state (busy=0): acts only when start=1 at an edge.
  - md_op 1–4: latch the computed result into internal pending hi/lo, set busy=1, load counter with MULT_CYCLES or DIV_CYCLES.
  - md_op 5: hi<=rs_val at that edge; busy stays 0.
  - md_op 6: lo<=rs_val at that edge; busy stays 0.
  - md_op 0 or 7: no state change.
- Busy state: counter decrements each edge. At the edge where counter goes 1->0, busy<=0 and hi/lo<=pending in the same edge.
  - busy is therefore high for exactly N cycles after the start edge.
  - hi/lo hold their old values throughout the busy window.
- start while busy=1: ignored entirely, including mthi/mtlo. No restart, no counter reload. This is an upstream protocol violation and must not corrupt the in-flight result.
- Start in the same cycle busy falls (busy still 1 at that edge): ignored.
- Arithmetic:
  - mult: signed 32x32->64, hi=[63:32], lo=[31:0].
  - multu: same, unsigned.
  - div: signed, quotient truncated toward zero -> lo; remainder with the dividend's sign -> hi.
  - divu: unsigned quotient -> lo, remainder -> hi.
  - Operands are sampled only at the start edge; later changes on rs_val/rt_val have no effect.
- Division by zero (rt_val=0, div or divu): busy asserts for the full DIV_CYCLES; hi/lo are left unchanged at completion.
- Signed overflow div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0x00000000.
- Latency summary: mthi/mtlo visible on hi/lo 1 cycle after start; mult results visible MULT_CYCLES cycles after the start edge; div results DIV_CYCLES cycles after.
- Outputs: no combinational paths from inputs to outputs; busy, hi, lo are all registered.

Test Plan:
- reset=1 for 3 cycles, then start=1 md_op=1 rs=0xFFFFFFFE rt=0x00000003 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA; hi/lo unchanged (0) while busy.
- multu rs=0xFFFFFFFF rt=0xFFFFFFFF -> after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
- div rs=0xFFFFFFF9 (-7) rt=2 -> busy 10 cycles; then lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu rs=7 rt=2 -> lo=3, hi=1.
- mthi rs=0x12345678, next cycle mtlo rs=0x9ABCDEF0 -> hi updates 1 cycle after the first start, lo 1 cycle after the second; busy never rises. Then div with rt=0 -> busy 10 cycles, hi/lo still 0x12345678/0x9ABCDEF0.
- Start mult 3x4, pulse start with md_op=5 rs=0xDEAD and md_op=3 during busy cycle 2 -> ignored; busy falls on schedule; hi=0, lo=12.
- Start div 100/7, assert reset at busy cycle 4 -> next edge busy=0, hi=lo=0; no late write after the original completion time. Then a new mult 2x3 gives lo=6.
